// File: rtl/router_port_rx.sv
// router_port_rx: receive front end for one router input port.
// Deserialises the frame_n/valid_n/din pin protocol into bytes tagged with
// destination and sop/eop/err. The tagged bytes are buffered in a byte FIFO,
// and the FIFO head is presented as a valid/ready stream to the fabric arbiter.
// Optional feature macro: ROUTER_RX_STATS_EN adds the pkt_cnt/err_cnt outputs.
module router_port_rx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int BUSY_THRESH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_n,
    input  logic       valid_n,
    input  logic       din,
    output logic       busy_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [3:0] out_dest,
    output logic       out_sop,
    output logic       out_eop,
    output logic       out_err
`ifdef ROUTER_RX_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 15;  // {err, eop, sop, dest[3:0], data[7:0]}
    localparam logic [PW-1:0] DEPTH_C  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] THRESH_C = PW'(BUSY_THRESH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_PAD  = 3'd2,
        S_DATA = 3'd3,
        S_DROP = 3'd4,
        S_TERM = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    dest_q, dest_d;
    logic [1:0]    addr_cnt_q, addr_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          sop_done_q, sop_done_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic          full_s, empty_s, pop_s, can_push_s;
    logic [PW-1:0] count_s, free_s;
    logic          push_s, push_sop_s, push_eop_s, push_err_s;
    logic [7:0]    push_data_s, shift_smp_s;
    logic          full_byte_s, runt_s, ovf_drop_s;
    logic [EW-1:0] head_s;

    // FIFO status; a pop in the same cycle frees a slot for a push into a full FIFO
    always_comb begin
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_s    = (wr_ptr_q == rd_ptr_q);
        pop_s      = !empty_s && out_ready;
        can_push_s = !full_s || pop_s;
        count_s    = wr_ptr_q - rd_ptr_q;
        free_s     = DEPTH_C - count_s;
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_s};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};
        busy_d     = !((free_s < THRESH_C) || (state_q == S_DROP) || (state_q == S_TERM));
    end

    // Receive FSM: address capture, payload deserialisation, overflow handling
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        addr_cnt_d  = addr_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        sop_done_d  = sop_done_q;
        push_s      = 1'b0;
        push_data_s = 8'h00;
        push_sop_s  = 1'b0;
        push_eop_s  = 1'b0;
        push_err_s  = 1'b0;
        shift_smp_s = shift_q;
        full_byte_s = 1'b0;
        runt_s      = 1'b0;
        ovf_drop_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!frame_n) begin
                    dest_d     = {3'b000, din};
                    addr_cnt_d = 2'd1;
                    sop_done_d = 1'b0;
                    shift_d    = 8'h00;
                    bit_cnt_d  = 3'd0;
                    state_d    = S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (frame_n) begin
                    runt_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    dest_d[addr_cnt_q] = din;
                    addr_cnt_d         = addr_cnt_q + 2'd1;
                    if (addr_cnt_q == 2'd3) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_PAD: begin
                if (frame_n) begin
                    runt_s  = 1'b1;
                    state_d = S_IDLE;
                end else if (!valid_n) begin
                    shift_d   = {7'b0000000, din};
                    bit_cnt_d = 3'd1;
                    state_d   = S_DATA;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DATA: begin
                if (!valid_n) begin
                    shift_smp_s = shift_q | ({7'b0000000, din} << bit_cnt_q);
                    full_byte_s = (bit_cnt_q == 3'd7);
                end else begin
                    shift_smp_s = shift_q;
                    full_byte_s = 1'b0;
                end
                if (full_byte_s || frame_n) begin
                    // A short final byte is still delivered, flagged as corrupt
                    push_data_s = shift_smp_s;
                    push_sop_s  = !sop_done_q;
                    push_eop_s  = frame_n;
                    push_err_s  = !full_byte_s;
                    shift_d     = 8'h00;
                    bit_cnt_d   = 3'd0;
                    if (can_push_s) begin
                        push_s     = 1'b1;
                        sop_done_d = 1'b1;
                        state_d    = frame_n ? S_IDLE : S_DATA;
                    end else if (!frame_n) begin
                        state_d = S_DROP;
                    end else if (sop_done_q) begin
                        state_d = S_TERM;
                    end else begin
                        ovf_drop_s = 1'b1;
                        state_d    = S_IDLE;
                    end
                end else if (!valid_n) begin
                    shift_d   = shift_smp_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DROP: begin
                if (!frame_n) begin
                    state_d = S_DROP;
                end else if (sop_done_q) begin
                    state_d = S_TERM;
                end else begin
                    ovf_drop_s = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_TERM: begin
                // Close a packet whose tail was dropped so the consumer sees an eop
                push_data_s = 8'h00;
                push_sop_s  = 1'b0;
                push_eop_s  = 1'b1;
                push_err_s  = 1'b1;
                if (can_push_s) begin
                    push_s  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TERM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating good-packet and error counters
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push_s && push_eop_s && !push_err_s && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if ((runt_s || (push_s && push_err_s) || ovf_drop_s) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

    // All state flops: FSM, deserialiser, FIFO storage and pointers, busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            dest_q     <= 4'h0;
            addr_cnt_q <= 2'd0;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            sop_done_q <= 1'b0;
            busy_q     <= 1'b1;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
`ifdef ROUTER_RX_STATS_EN
            pkt_cnt_q  <= 16'h0000;
            err_cnt_q  <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            addr_cnt_q <= addr_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sop_done_q <= sop_done_d;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {push_err_s, push_eop_s, push_sop_s, dest_q, push_data_s};
            end
`ifdef ROUTER_RX_STATS_EN
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid = !empty_s;
    assign out_data  = head_s[7:0];
    assign out_dest  = head_s[11:8];
    assign out_sop   = head_s[12];
    assign out_eop   = head_s[13];
    assign out_err   = head_s[14];
    assign busy_n    = busy_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Directed testbench for router_port_rx (default FIFO_DEPTH=16, BUSY_THRESH=4).
module tb_router_port_rx;

    logic        clk = 1'b0;
    logic        reset_n, frame_n, valid_n, din, out_ready;
    logic        busy_n, out_valid, out_sop, out_eop, out_err;
    logic [7:0]  out_data;
    logic [3:0]  out_dest;
`ifdef ROUTER_RX_STATS_EN
    logic [15:0] pkt_cnt, err_cnt;
`endif

    int vec  = 0;
    int errs = 0;
    logic [14:0] mon_q[$];

    always #5 clk = ~clk;

    router_port_rx #(.FIFO_DEPTH(16), .BUSY_THRESH(4)) dut (
        .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
        .busy_n(busy_n), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err)
`ifdef ROUTER_RX_STATS_EN
        , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
    );

    function automatic logic [14:0] ent(input logic err, input logic eop, input logic sop,
                                        input logic [3:0] dest, input logic [7:0] data);
        return {err, eop, sop, dest, data};
    endfunction

    // One clock: drive at negedge, log the handshake that the next posedge performs
    task automatic cyc(input logic f, input logic v, input logic d);
        @(negedge clk);
        frame_n = f;
        valid_n = v;
        din     = d;
        if (out_valid && out_ready) mon_q.push_back({out_err, out_eop, out_sop, out_dest, out_data});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mon_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] addr, input int npad, input logic [199:0] pay,
                              input int nbits, input int ready_at, input int busy_byte,
                              input bit lat_chk);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, addr[i]);
        for (int i = 0; i < npad; i++) cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == ready_at) out_ready = 1'b1;
            cyc((i == nbits - 1), 1'b0, pay[i]);
            if (lat_chk && (i % 8 == 7)) begin
                vec++;
                if (out_valid !== 1'b1) begin errs++; $display("FAIL latency_hi bit %0d: out_valid %b want 1", i, out_valid); end
            end
            if (lat_chk && (i % 8 == 6)) begin
                vec++;
                if (out_valid !== 1'b0) begin errs++; $display("FAIL latency_lo bit %0d: out_valid %b want 0", i, out_valid); end
            end
            if (busy_byte > 0 && i == 8 * busy_byte - 1) begin
                vec++;
                if (busy_n !== 1'b1) begin errs++; $display("FAIL busy_early bit %0d: busy_n %b want 1", i, busy_n); end
            end
            if (busy_byte > 0 && i == 8 * busy_byte) begin
                vec++;
                if (busy_n !== 1'b0) begin errs++; $display("FAIL busy_low bit %0d: busy_n %b want 0", i, busy_n); end
            end
        end
    endtask

    task automatic test_reset();
        vec++;
        if ({busy_n, out_valid, out_data, out_dest, out_sop, out_eop, out_err} !== {1'b1, 1'b0, 8'h00, 4'h0, 3'b000}) begin
            errs++;
            $display("FAIL reset_vals: busy %b vld %b data %h dest %h sop %b eop %b err %b", busy_n, out_valid, out_data, out_dest, out_sop, out_eop, out_err);
        end
    endtask

    task automatic test_two_bytes();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b1;
        pay = '0;
        pay[7:0] = 8'h3C; pay[15:8] = 8'hA5;
        send_frame(4'hA, 5, pay, 16, -1, 0, 1'b1);
        idle(3);
        exp = '{ent(1'b0, 1'b0, 1'b1, 4'hA, 8'h3C), ent(1'b0, 1'b1, 1'b0, 4'hA, 8'hA5)};
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL two_bytes_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL two_bytes[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    task automatic test_partial_byte();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b1;
        pay = '0;
        pay[7:0] = 8'hC3; pay[8] = 1'b1; pay[9] = 1'b0; pay[10] = 1'b1;
        send_frame(4'h3, 0, pay, 11, -1, 0, 1'b1);
        idle(3);
        exp = '{ent(1'b0, 1'b0, 1'b1, 4'h3, 8'hC3), ent(1'b1, 1'b1, 1'b0, 4'h3, 8'h05)};
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL partial_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL partial[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    task automatic test_runt();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        idle(4);
        vec++;
        if (mon_q.size() !== 0 || out_valid !== 1'b0 || busy_n !== 1'b1) begin
            errs++; $display("FAIL runt_nopush: pushes %0d vld %b busy %b want 0 0 1", mon_q.size(), out_valid, busy_n);
        end
`ifdef ROUTER_RX_STATS_EN
        vec++;
        if (err_cnt !== 16'd1) begin errs++; $display("FAIL runt_errcnt: got %0d want 1", err_cnt); end
`endif
        pay = '0;
        pay[7:0] = 8'h5A;
        send_frame(4'hE, 1, pay, 8, -1, 0, 1'b0);
        idle(3);
        exp = '{ent(1'b0, 1'b1, 1'b1, 4'hE, 8'h5A)};
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL runt_next_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL runt_next[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    task automatic test_overflow();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b0;
        pay = '0;
        for (int k = 0; k < 20; k++) pay[8*k +: 8] = 8'h10 + 8'(k);
        send_frame(4'h6, 1, pay, 160, -1, 13, 1'b0);
        idle(2);
        vec++;
        if (busy_n !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h10) begin
            errs++; $display("FAIL ovf_hold: busy %b vld %b data %h want 0 1 10", busy_n, out_valid, out_data);
        end
        out_ready = 1'b1;
        idle(25);
        for (int k = 0; k < 16; k++) exp.push_back(ent(1'b0, 1'b0, (k == 0), 4'h6, 8'h10 + 8'(k)));
        exp.push_back(ent(1'b1, 1'b1, 1'b0, 4'h6, 8'h00));
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL ovf_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL ovf[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
        vec++;
        if (busy_n !== 1'b1) begin errs++; $display("FAIL ovf_busy_release: busy_n %b want 1", busy_n); end
    endtask

    task automatic test_full_push_pop();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b0;
        pay = '0;
        for (int k = 0; k < 17; k++) pay[8*k +: 8] = 8'h40 + 8'(k);
        send_frame(4'hB, 0, pay, 136, 135, 0, 1'b0);
        out_ready = 1'b0;
        vec++;
        if (mon_q.size() !== 1 || out_valid !== 1'b1 || out_data !== 8'h41) begin
            errs++; $display("FAIL fullpp_edge: pops %0d vld %b data %h want 1 1 41", mon_q.size(), out_valid, out_data);
        end
        idle(2);
        out_ready = 1'b1;
        idle(20);
        for (int k = 0; k < 17; k++) exp.push_back(ent(1'b0, (k == 16), (k == 0), 4'hB, 8'h40 + 8'(k)));
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL fullpp_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL fullpp[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [199:0] pay;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b1;
        pay = '0;
        pay[7:0] = 8'h11;
        send_frame(4'h5, 0, pay, 8, -1, 0, 1'b0);
        pay[7:0] = 8'hF0;
        send_frame(4'h9, 2, pay, 8, -1, 0, 1'b0);
        idle(3);
        exp = '{ent(1'b0, 1'b1, 1'b1, 4'h5, 8'h11), ent(1'b0, 1'b1, 1'b1, 4'h9, 8'hF0)};
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL b2b_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL b2b[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [199:0] pay;
        logic [3:0]   a;
        logic [14:0]  exp[$];
        do_reset();
        out_ready = 1'b0;
        a = 4'h2;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, a[i]);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, i[0]);
        vec++;
        if (out_valid !== 1'b1) begin errs++; $display("FAIL midrst_pre: out_valid %b want 1", out_valid); end
        @(negedge clk);
        reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0;
        #1;
        vec++;
        if ({busy_n, out_valid, out_data, out_dest, out_sop, out_eop, out_err} !== {1'b1, 1'b0, 8'h00, 4'h0, 3'b000}) begin
            errs++; $display("FAIL midrst_vals: busy %b vld %b data %h dest %h", busy_n, out_valid, out_data, out_dest);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        mon_q.delete();
        pay = '0;
        pay[7:0] = 8'h81;
        send_frame(4'h7, 1, pay, 8, -1, 0, 1'b0);
        idle(3);
        exp = '{ent(1'b0, 1'b1, 1'b1, 4'h7, 8'h81)};
        vec++;
        if (mon_q.size() !== exp.size()) begin errs++; $display("FAIL midrst_cnt: got %0d want %0d", mon_q.size(), exp.size()); end
        for (int k = 0; k < exp.size() && k < mon_q.size(); k++) begin
            vec++;
            if (mon_q[k] !== exp[k]) begin errs++; $display("FAIL midrst[%0d]: got %h want %h", k, mon_q[k], exp[k]); end
        end
    endtask

    initial begin
        reset_n = 1'b0; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_two_bytes();
        test_partial_byte();
        test_runt();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
